// File: rtl/call_stack_ctrl_pkg.sv
// Shared definitions for the return-stack sequencer and the stack it drives.
//   CS_PC_W / CS_FLAGS_W / CS_DEPTH / CS_DEPTH_W : default widths and stack depth
//   state_e : sequencer states
//   op_e    : operation latched when a request is accepted
package call_stack_ctrl_pkg;

   localparam int CS_PC_W    = 9;
   localparam int CS_FLAGS_W = 4;
   localparam int CS_DEPTH   = 5;
   localparam int CS_DEPTH_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH,
      ST_POP,
      ST_REJ,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_CALL,
      OP_IRQ,
      OP_RET,
      OP_RETI
   } op_e;

endpackage

// File: rtl/call_stack_ctrl_if.sv
// Bundle of the request side (decoder / interrupt unit), the stack side and the
// status outputs of call_stack_ctrl.
//   slave  : the controller (requests and stack TOS in; strobes and status out)
//   master : the environment driving requests and hosting the stack
interface call_stack_ctrl_if
   import call_stack_ctrl_pkg::*;
#(
   parameter int PC_W    = CS_PC_W,
   parameter int FLAGS_W = CS_FLAGS_W,
   parameter int DEPTH_W = CS_DEPTH_W
);

   logic               call_req;
   logic               ret_req;
   logic               is_reti;
   logic               irq_req;
   logic [PC_W-1:0]    cur_pc;
   logic [FLAGS_W-1:0] cur_flags;
   logic               fault_clr;
   logic [PC_W-1:0]    stk_out_pc;
   logic [FLAGS_W-1:0] stk_out_fl;

   logic               push_en;
   logic               pop_en;
   logic [PC_W-1:0]    stk_in_pc;
   logic [FLAGS_W-1:0] stk_in_fl;
   logic               ready;
   logic               done;
   logic               ret_valid;
   logic [PC_W-1:0]    ret_pc;
   logic [FLAGS_W-1:0] ret_flags;
   logic               irq_ack;
   logic               isr_active;
   logic [DEPTH_W-1:0] depth;
   logic               ovf;
   logic               unf;

   modport slave (
      input  call_req, ret_req, is_reti, irq_req, cur_pc, cur_flags, fault_clr,
             stk_out_pc, stk_out_fl,
      output push_en, pop_en, stk_in_pc, stk_in_fl, ready, done, ret_valid,
             ret_pc, ret_flags, irq_ack, isr_active, depth, ovf, unf
   );

   modport master (
      output call_req, ret_req, is_reti, irq_req, cur_pc, cur_flags, fault_clr,
             stk_out_pc, stk_out_fl,
      input  push_en, pop_en, stk_in_pc, stk_in_fl, ready, done, ret_valid,
             ret_pc, ret_flags, irq_ack, isr_active, depth, ovf, unf
   );

endinterface

// File: rtl/call_stack_ctrl.sv
// Sequencer for the PC/flags return stack. Arbitrates IRQ entry, CALL and RET/RETI,
// issues single-cycle push/pop strobes, latches popped PC/flags, tracks depth and
// raises sticky overflow/underflow before the stack would be corrupted.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : call_stack_ctrl_if.slave (requests, stack TOS, strobes, status)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready; arbitrates irq (if no ISR active) > call > ret
//   PUSH    | push_en strobe, depth+1, ISR marked active for IRQ entry
//   POP     | pop_en strobe, TOS captured into ret_pc/ret_flags, depth-1
//   REJ     | overflow/underflow rejection, no strobes
//   DONE    | done pulse (ret_valid too when coming from POP)
module call_stack_ctrl
   import call_stack_ctrl_pkg::*;
#(
   parameter int PC_W    = CS_PC_W,
   parameter int FLAGS_W = CS_FLAGS_W,
   parameter int DEPTH   = CS_DEPTH,
   parameter int DEPTH_W = CS_DEPTH_W
) (
   input logic               clk,
   input logic               rst,
   call_stack_ctrl_if.slave  bus
);

   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [PC_W-1:0]    stk_in_pc_q, stk_in_pc_d;
   logic [FLAGS_W-1:0] stk_in_fl_q, stk_in_fl_d;
   logic [PC_W-1:0]    ret_pc_q, ret_pc_d;
   logic [FLAGS_W-1:0] ret_fl_q, ret_fl_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               isr_q, isr_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               was_pop_q, was_pop_d;
   logic               ovf_set, unf_set;
   logic               irq_win;

   // IRQ entry is only eligible while no ISR is in progress (no nesting).
   assign irq_win = (state_q == ST_IDLE) && bus.irq_req && !isr_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      stk_in_pc_d = stk_in_pc_q;
      stk_in_fl_d = stk_in_fl_q;
      ret_pc_d    = ret_pc_q;
      ret_fl_d    = ret_fl_q;
      depth_d     = depth_q;
      isr_d       = isr_q;
      was_pop_d   = was_pop_q;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (irq_win || bus.call_req) begin
               op_d        = irq_win ? OP_IRQ : OP_CALL;
               stk_in_pc_d = bus.cur_pc;
               stk_in_fl_d = bus.cur_flags;
               if (depth_q == DEPTH_FULL) begin
                  ovf_set = 1'b1;
                  state_d = ST_REJ;
               end else begin
                  state_d = ST_PUSH;
               end
            end else if (bus.ret_req) begin
               op_d = bus.is_reti ? OP_RETI : OP_RET;
               if (depth_q == '0) begin
                  unf_set = 1'b1;
                  state_d = ST_REJ;
               end else begin
                  state_d = ST_POP;
               end
            end
         end
         ST_PUSH: begin
            depth_d   = depth_q + DEPTH_ONE;
            was_pop_d = 1'b0;
            if (op_q == OP_IRQ) isr_d = 1'b1;
            state_d   = ST_DONE;
         end
         ST_POP: begin
            // TOS is sampled on the same edge the stack pops, so it is the pre-pop entry.
            ret_pc_d  = bus.stk_out_pc;
            ret_fl_d  = bus.stk_out_fl;
            depth_d   = depth_q - DEPTH_ONE;
            was_pop_d = 1'b1;
            if (op_q == OP_RETI) isr_d = 1'b0;
            state_d   = ST_DONE;
         end
         ST_REJ: begin
            was_pop_d = 1'b0;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fault raised on this edge takes precedence over a clear.
      ovf_d = ovf_set | (ovf_q & ~bus.fault_clr);
      unf_d = unf_set | (unf_q & ~bus.fault_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_CALL;
         stk_in_pc_q <= '0;
         stk_in_fl_q <= '0;
         ret_pc_q    <= '0;
         ret_fl_q    <= '0;
         depth_q     <= '0;
         isr_q       <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         was_pop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         stk_in_pc_q <= stk_in_pc_d;
         stk_in_fl_q <= stk_in_fl_d;
         ret_pc_q    <= ret_pc_d;
         ret_fl_q    <= ret_fl_d;
         depth_q     <= depth_d;
         isr_q       <= isr_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         was_pop_q   <= was_pop_d;
      end
   end

   assign bus.push_en    = (state_q == ST_PUSH);
   assign bus.pop_en     = (state_q == ST_POP);
   assign bus.stk_in_pc  = stk_in_pc_q;
   assign bus.stk_in_fl  = stk_in_fl_q;
   assign bus.ready      = (state_q == ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.ret_valid  = (state_q == ST_DONE) && was_pop_q;
   assign bus.ret_pc     = ret_pc_q;
   assign bus.ret_flags  = ret_fl_q;
   assign bus.irq_ack    = irq_win;
   assign bus.isr_active = isr_q;
   assign bus.depth      = depth_q;
   assign bus.ovf        = ovf_q;
   assign bus.unf        = unf_q;

endmodule
